// File: rtl/butterfly_network_pkg.sv
// Shared sizing, packet field offsets and helpers for the butterfly
// shared-memory interconnect.
package butterfly_network_pkg;

    localparam int N             = 8;
    localparam int STAGES        = 3;
    localparam int DATA_W        = 8;
    localparam int OFF_W         = 2;
    localparam int PACKET_W      = 1 + 2*STAGES + OFF_W + DATA_W;
    localparam int BACK_PACKET_W = STAGES + DATA_W;

    localparam int DATA_LSB = 0;
    localparam int SRC_LSB  = DATA_LSB + DATA_W;
    localparam int OFF_LSB  = SRC_LSB + STAGES;
    localparam int DEST_LSB = OFF_LSB + OFF_W;
    localparam int OP_BIT   = DEST_LSB + STAGES;
    localparam int BSRC_LSB = DATA_W;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int COLLISION_COUNT_W = clog2(STAGES*N/2);

    // Lower line of switch j in a stage whose pair distance is m.
    function automatic int pair_lo(input int j, input int m);
        return (j / m) * 2 * m + (j % m);
    endfunction

endpackage

// File: rtl/butterfly_network_switch.sv
// 2x2 butterfly switch: steers each valid input by one packet bit.
// in0 sits on the lower line and wins when both want the same output.
module bfly_switch2x2 #(
    parameter int W   = 17,
    parameter int SEL = 0
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         v0_in,
    input  logic         v1_in,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic         v0_out,
    output logic         v1_out,
    output logic         collision
);

    always_comb begin
        out0      = '0;
        out1      = '0;
        v0_out    = 1'b0;
        v1_out    = 1'b0;
        collision = v0_in && v1_in && (in0[SEL] == in1[SEL]);
        if (v0_in) begin
            if (in0[SEL]) begin
                out1   = in0;
                v1_out = 1'b1;
            end else begin
                out0   = in0;
                v0_out = 1'b1;
            end
        end
        if (v1_in && !collision) begin
            if (in1[SEL]) begin
                out1   = in1;
                v1_out = 1'b1;
            end else begin
                out0   = in1;
                v0_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/butterfly_network.sv
// N-core to N-bank interconnect: forward butterfly, register-file banks,
// mirrored backward butterfly, with collision drop reporting.
module butterfly_network
    import butterfly_network_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N*PACKET_W-1:0]          in_flat,
    input  logic [N-1:0]                   valid_in,
    output logic [N*BACK_PACKET_W-1:0]     out_flat,
    output logic [N-1:0]                   valid_back_out,
    output logic [N-1:0]                   dropped_core_bus,
    output logic [COLLISION_COUNT_W-1:0]   total_collisions
);

    localparam int WORDS = 1 << OFF_W;
    localparam int LAST  = STAGES - 1;
    localparam int CMAX  = (1 << COLLISION_COUNT_W) - 1;

    logic [PACKET_W-1:0]      fwd_in_pkt [STAGES][N];
    logic [N-1:0]             fwd_in_v   [STAGES];
    logic [PACKET_W-1:0]      fwd_pkt_d  [STAGES][N];
    logic [PACKET_W-1:0]      fwd_pkt_q  [STAGES][N];
    logic [N-1:0]             fwd_v_d    [STAGES];
    logic [N-1:0]             fwd_v_q    [STAGES];
    logic [N/2-1:0]           fwd_coll   [STAGES];

    logic [DATA_W-1:0]        mem_d [N][WORDS];
    logic [DATA_W-1:0]        mem_q [N][WORDS];
    logic [BACK_PACKET_W-1:0] resp_pkt_d [N];
    logic [BACK_PACKET_W-1:0] resp_pkt_q [N];
    logic [N-1:0]             resp_v_d;
    logic [N-1:0]             resp_v_q;

    logic [BACK_PACKET_W-1:0] bwd_in_pkt [STAGES][N];
    logic [N-1:0]             bwd_in_v   [STAGES];
    logic [BACK_PACKET_W-1:0] bwd_pkt_d  [STAGES][N];
    logic [BACK_PACKET_W-1:0] bwd_pkt_q  [STAGES][N];
    logic [N-1:0]             bwd_v_d    [STAGES];
    logic [N-1:0]             bwd_v_q    [STAGES];
    logic [N/2-1:0]           bwd_coll_unused [STAGES];

    logic [N-1:0]                 dropped_d;
    logic [N-1:0]                 dropped_q;
    logic [COLLISION_COUNT_W-1:0] coll_d;
    logic [COLLISION_COUNT_W-1:0] coll_q;
    int                           coll_sum;
    int                           coll_tot;
    int                           hi_idx;

    for (genvar c = 0; c < N; c++) begin : g_in
        assign fwd_in_pkt[0][c] = in_flat[c*PACKET_W +: PACKET_W];
        assign bwd_in_pkt[0][c] = resp_pkt_q[c];
    end
    assign fwd_in_v[0] = valid_in;
    assign bwd_in_v[0] = resp_v_q;

    for (genvar s = 1; s < STAGES; s++) begin : g_link
        for (genvar c = 0; c < N; c++) begin : g_line
            assign fwd_in_pkt[s][c] = fwd_pkt_q[s-1][c];
            assign bwd_in_pkt[s][c] = bwd_pkt_q[s-1][c];
        end
        assign fwd_in_v[s] = fwd_v_q[s-1];
        assign bwd_in_v[s] = bwd_v_q[s-1];
    end

    // Forward stages resolve dest MSB first; backward stages src LSB first.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FM = 1 << (STAGES - 1 - s);
        localparam int BM = 1 << s;
        for (genvar j = 0; j < N/2; j++) begin : g_sw
            localparam int FLO = pair_lo(j, FM);
            localparam int BLO = pair_lo(j, BM);
            bfly_switch2x2 #(
                .W   (PACKET_W),
                .SEL (DEST_LSB + STAGES - 1 - s)
            ) u_fwd (
                .in0       (fwd_in_pkt[s][FLO]),
                .in1       (fwd_in_pkt[s][FLO+FM]),
                .v0_in     (fwd_in_v[s][FLO]),
                .v1_in     (fwd_in_v[s][FLO+FM]),
                .out0      (fwd_pkt_d[s][FLO]),
                .out1      (fwd_pkt_d[s][FLO+FM]),
                .v0_out    (fwd_v_d[s][FLO]),
                .v1_out    (fwd_v_d[s][FLO+FM]),
                .collision (fwd_coll[s][j])
            );
            bfly_switch2x2 #(
                .W   (BACK_PACKET_W),
                .SEL (BSRC_LSB + s)
            ) u_bwd (
                .in0       (bwd_in_pkt[s][BLO]),
                .in1       (bwd_in_pkt[s][BLO+BM]),
                .v0_in     (bwd_in_v[s][BLO]),
                .v1_in     (bwd_in_v[s][BLO+BM]),
                .out0      (bwd_pkt_d[s][BLO]),
                .out1      (bwd_pkt_d[s][BLO+BM]),
                .v0_out    (bwd_v_d[s][BLO]),
                .v1_out    (bwd_v_d[s][BLO+BM]),
                .collision (bwd_coll_unused[s][j])
            );
        end
    end

    // The losing packet is always the one on the upper line of the pair.
    always_comb begin
        dropped_d = '0;
        coll_sum  = 0;
        hi_idx    = 0;
        for (int s = 0; s < STAGES; s++) begin
            for (int j = 0; j < N/2; j++) begin
                if (fwd_coll[s][j]) begin
                    hi_idx = pair_lo(j, 1 << (STAGES-1-s)) + (1 << (STAGES-1-s));
                    dropped_d[fwd_in_pkt[s][hi_idx][SRC_LSB +: STAGES]] = 1'b1;
                    coll_sum = coll_sum + 1;
                end
            end
        end
        coll_tot = int'(coll_q) + coll_sum;
        coll_d   = (coll_tot > CMAX) ? COLLISION_COUNT_W'(CMAX)
                                     : COLLISION_COUNT_W'(coll_tot);
    end

    // Reads return the word as it stood before this edge's write.
    always_comb begin
        mem_d    = mem_q;
        resp_v_d = fwd_v_q[LAST];
        for (int b = 0; b < N; b++) begin
            resp_pkt_d[b] = '0;
            if (fwd_v_q[LAST][b]) begin
                if (fwd_pkt_q[LAST][b][OP_BIT]) begin
                    mem_d[b][fwd_pkt_q[LAST][b][OFF_LSB +: OFF_W]] =
                        fwd_pkt_q[LAST][b][DATA_LSB +: DATA_W];
                    resp_pkt_d[b] = {fwd_pkt_q[LAST][b][SRC_LSB +: STAGES],
                                     fwd_pkt_q[LAST][b][DATA_LSB +: DATA_W]};
                end else begin
                    resp_pkt_d[b] = {fwd_pkt_q[LAST][b][SRC_LSB +: STAGES],
                                     mem_q[b][fwd_pkt_q[LAST][b][OFF_LSB +: OFF_W]]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                fwd_v_q[s] <= '0;
                bwd_v_q[s] <= '0;
                for (int c = 0; c < N; c++) begin
                    fwd_pkt_q[s][c] <= '0;
                    bwd_pkt_q[s][c] <= '0;
                end
            end
            for (int b = 0; b < N; b++) begin
                resp_pkt_q[b] <= '0;
                for (int w = 0; w < WORDS; w++) begin
                    mem_q[b][w] <= '0;
                end
            end
            resp_v_q  <= '0;
            dropped_q <= '0;
            coll_q    <= '0;
        end else begin
            fwd_pkt_q  <= fwd_pkt_d;
            fwd_v_q    <= fwd_v_d;
            bwd_pkt_q  <= bwd_pkt_d;
            bwd_v_q    <= bwd_v_d;
            resp_pkt_q <= resp_pkt_d;
            resp_v_q   <= resp_v_d;
            mem_q      <= mem_d;
            dropped_q  <= dropped_d;
            coll_q     <= coll_d;
        end
    end

    always_comb begin
        out_flat = '0;
        for (int c = 0; c < N; c++) begin
            out_flat[c*BACK_PACKET_W +: BACK_PACKET_W] = bwd_pkt_q[LAST][c];
        end
    end

    assign valid_back_out   = bwd_v_q[LAST];
    assign dropped_core_bus = dropped_q;
    assign total_collisions = coll_q;

endmodule

// File: tb/tb_butterfly_network.sv
// Self-checking bench for butterfly_network: path-level routing model,
// per-cycle compare, and hand-computed directed expectations.
module tb_butterfly_network;
    import butterfly_network_pkg::*;

    localparam int H = 1024;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [N*PACKET_W-1:0]        in_flat;
    logic [N-1:0]                 valid_in;
    logic [N*BACK_PACKET_W-1:0]   out_flat;
    logic [N-1:0]                 valid_back_out;
    logic [N-1:0]                 dropped_core_bus;
    logic [COLLISION_COUNT_W-1:0] total_collisions;

    butterfly_network dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_flat          (in_flat),
        .valid_in         (valid_in),
        .out_flat         (out_flat),
        .valid_back_out   (valid_back_out),
        .dropped_core_bus (dropped_core_bus),
        .total_collisions (total_collisions)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [N-1:0]             e_vb   [H];
    logic [N-1:0]             e_drop [H];
    logic [BACK_PACKET_W-1:0] e_out  [H][N];
    int                       e_coll [H];
    logic [7:0]               mdl_mem [N][4];
    int                       tc_m;

    logic       r_op   [N];
    logic [2:0] r_dest [N];
    logic [1:0] r_off  [N];
    logic [7:0] r_data [N];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < H; i++) begin
            e_vb[i]   = '0;
            e_drop[i] = '0;
            e_coll[i] = 0;
            for (int c = 0; c < N; c++) e_out[i][c] = '0;
        end
        for (int b = 0; b < N; b++)
            for (int w = 0; w < 4; w++) mdl_mem[b][w] = '0;
        tc_m = 0;
    endtask

    task automatic clr_req();
        for (int c = 0; c < N; c++) begin
            r_op[c]   = 1'b0;
            r_dest[c] = '0;
            r_off[c]  = '0;
            r_data[c] = '0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the
    // sampling edge. A packet's line after stage s is its source line with
    // the top s+1 bits replaced by the dest bits; two packets landing on the
    // same line collide and the one from the higher line loses.
    task automatic issue(input logic [N-1:0] vm);
        int  t;
        int  pos [N];
        int  np  [N];
        bit  alive [N];
        int  bi;
        int  lo;
        logic [7:0] rv;
        t = cyc + 1;
        for (int c = 0; c < N; c++) begin
            in_flat[c*PACKET_W +: PACKET_W] =
                {r_op[c], r_dest[c], r_off[c], 3'(c), r_data[c]};
            pos[c]   = c;
            alive[c] = vm[c];
        end
        valid_in = vm;
        for (int s = 0; s < STAGES; s++) begin
            bi = STAGES - 1 - s;
            for (int c = 0; c < N; c++)
                np[c] = (pos[c] & ~(1 << bi)) | (int'(r_dest[c][bi]) << bi);
            for (int a = 0; a < N; a++) begin
                for (int b = a + 1; b < N; b++) begin
                    if (alive[a] && alive[b] && np[a] == np[b]) begin
                        lo = (pos[a] > pos[b]) ? a : b;
                        alive[lo] = 1'b0;
                        e_drop[(t+s)%H][lo] = 1'b1;
                        e_coll[(t+s)%H]++;
                    end
                end
            end
            for (int c = 0; c < N; c++) pos[c] = np[c];
        end
        for (int c = 0; c < N; c++) begin
            if (alive[c]) begin
                if (r_op[c]) begin
                    mdl_mem[r_dest[c]][r_off[c]] = r_data[c];
                    rv = r_data[c];
                end else begin
                    rv = mdl_mem[r_dest[c]][r_off[c]];
                end
                e_vb[(t+6)%H][c]  = 1'b1;
                e_out[(t+6)%H][c] = {3'(c), rv};
            end
        end
        @(negedge clk);
        valid_in = '0;
        in_flat  = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [N*BACK_PACKET_W-1:0] eo;
            tc_m = tc_m + e_coll[cyc%H];
            if (tc_m > 15) tc_m = 15;
            for (int c = 0; c < N; c++)
                eo[c*BACK_PACKET_W +: BACK_PACKET_W] = e_out[cyc%H][c];
            chk("cyc_valid_back", valid_back_out, e_vb[cyc%H]);
            chk("cyc_out_flat", out_flat, eo);
            chk("cyc_dropped", dropped_core_bus, e_drop[cyc%H]);
            chk("cyc_collisions", total_collisions, tc_m);
        end
    end

    logic [N-1:0] acc;

    initial begin
        valid_in = '0;
        in_flat  = '0;
        clear_model();
        clr_req();
        repeat (2) @(negedge clk);
        chk("reset_valid_back", valid_back_out, 8'h00);
        chk("reset_out_flat", out_flat, '0);
        chk("reset_dropped", dropped_core_bus, 8'h00);
        chk("reset_collisions", total_collisions, 4'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // core 2 writes 0xA5 to bank 5 offset 1
        clr_req();
        r_op[2] = 1'b1; r_dest[2] = 3'd5; r_off[2] = 2'd1; r_data[2] = 8'hA5;
        issue(8'h04);
        repeat (5) @(negedge clk);
        chk("wr_early_valid", valid_back_out, 8'h00);
        @(negedge clk);
        chk("wr_valid", valid_back_out, 8'h04);
        chk("wr_resp", out_flat[2*BACK_PACKET_W +: BACK_PACKET_W], 11'h2A5);
        chk("wr_coll", total_collisions, 4'd0);

        // core 2 reads it back
        clr_req();
        r_dest[2] = 3'd5; r_off[2] = 2'd1;
        issue(8'h04);
        repeat (6) @(negedge clk);
        chk("rd_resp", out_flat[2*BACK_PACKET_W +: BACK_PACKET_W], 11'h2A5);

        // identity permutation reads
        clr_req();
        for (int c = 0; c < N; c++) r_dest[c] = 3'(c);
        issue(8'hFF);
        repeat (6) @(negedge clk);
        chk("id_valid", valid_back_out, 8'hFF);
        chk("id_coll", total_collisions, 4'd0);

        // back-to-back: XOR-5 writes then XOR-3 reads of offset 3
        clr_req();
        for (int c = 0; c < N; c++) begin
            r_op[c] = 1'b1; r_dest[c] = 3'(c ^ 5); r_off[c] = 2'd3;
            r_data[c] = 8'(8'h10 + c);
        end
        issue(8'hFF);
        clr_req();
        for (int c = 0; c < N; c++) begin
            r_dest[c] = 3'(c ^ 3); r_off[c] = 2'd3;
        end
        issue(8'hFF);
        repeat (5) @(negedge clk);
        chk("xor_wr_valid", valid_back_out, 8'hFF);
        chk("xor_wr_c0", out_flat[0 +: BACK_PACKET_W], 11'h010);
        @(negedge clk);
        chk("xor_rd_c0", out_flat[0 +: BACK_PACKET_W], 11'h016);
        chk("xor_rd_c1", out_flat[BACK_PACKET_W +: BACK_PACKET_W], 11'h117);

        // cores 0 and 1 both to bank 0: meet at the last stage
        clr_req();
        issue(8'h03);
        chk("pair_drop_s0", dropped_core_bus, 8'h00);
        repeat (2) @(negedge clk);
        chk("pair_drop_s2", dropped_core_bus, 8'h02);
        chk("pair_coll", total_collisions, 4'd1);
        @(negedge clk);
        chk("pair_drop_clear", dropped_core_bus, 8'h00);
        repeat (3) @(negedge clk);
        chk("pair_valid", valid_back_out, 8'h01);

        // all cores to bank 3
        clr_req();
        for (int c = 0; c < N; c++) begin
            r_dest[c] = 3'd3; r_off[c] = 2'd2;
        end
        acc = '0;
        issue(8'hFF);
        chk("all3_drop_s0", dropped_core_bus, 8'hF0);
        acc |= dropped_core_bus;
        @(negedge clk);
        acc |= dropped_core_bus;
        @(negedge clk);
        acc |= dropped_core_bus;
        chk("all3_drop_or", acc, 8'hFE);
        chk("all3_coll", total_collisions, 4'd8);
        repeat (4) @(negedge clk);
        chk("all3_valid", valid_back_out, 8'h01);

        // two more hot-spot bursts push the count past its ceiling
        clr_req();
        for (int c = 0; c < N; c++) r_dest[c] = 3'd6;
        issue(8'hFF);
        issue(8'hFF);
        repeat (4) @(negedge clk);
        chk("sat_coll", total_collisions, 4'd15);

        // reset while a write response is on the outputs
        clr_req();
        r_op[1] = 1'b1; r_dest[1] = 3'd4; r_off[1] = 2'd2; r_data[1] = 8'h3C;
        issue(8'h02);
        clr_req();
        for (int c = 0; c < N; c++) begin
            r_dest[c] = 3'(c); r_off[c] = 2'd2;
        end
        issue(8'hFF);
        repeat (5) @(negedge clk);
        chk("pre_rst_valid", valid_back_out, 8'h02);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("rst_valid", valid_back_out, 8'h00);
        chk("rst_out", out_flat, '0);
        chk("rst_coll", total_collisions, 4'd0);
        chk("rst_drop", dropped_core_bus, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr_req();
        r_dest[1] = 3'd4; r_off[1] = 2'd2;
        issue(8'h02);
        repeat (6) @(negedge clk);
        chk("post_rst_valid", valid_back_out, 8'h02);
        chk("post_rst_rd", out_flat[BACK_PACKET_W +: BACK_PACKET_W], 11'h100);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
